ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the attached keyboard over the same ps2c/ps2d lines the keyboard receiver listens on.
- It sits in main_module beside keyboard. The CPU loads a byte through a memory-mapped write and polls status.
- The block drives the open-drain lines through pull-low enables. main_module builds the tri-state pads.
- busy gates the receiver so it ignores the host's own frame.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- INHIBIT_CYCLES, 5000, cycles ps2c is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750_000, maximum cycles from clock release to the end of the ACK (15 ms).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- ps2c_in, input, 1, raw PS/2 clock pad level, asynchronous.
- ps2d_in, input, 1, raw PS/2 data pad level, asynchronous.
- ps2c_pull, output, 1, 1 = drive ps2c low, 0 = release (high-Z).
- ps2d_pull, output, 1, 1 = drive ps2d low, 0 = release.
- tx_data, input, 8, byte to send; sampled when tx_start is accepted.
- tx_start, input, 1, single-cycle request (CPU write strobe).
- busy, output, 1, high from the cycle after acceptance until done.
- done, output, 1, one-cycle pulse when the transfer ends, successfully or not.
- ack_ok, output, 1, device ACKed the last frame; held until the next acceptance.
- timeout, output, 1, last frame aborted on timeout; held until the next acceptance.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: ps2c_pull=0, ps2d_pull=0, busy=0, done=0, ack_ok=0, timeout=0, state IDLE. All outputs are registered.
- Reset mid-frame releases both lines immediately, asynchronously.
- Input sync: ps2c_in and ps2d_in pass through 2-FF synchronizers. A falling edge fe means previous synced clock = 1 and current = 0, so fe is 3 cycles after the pad edge.

States:
- IDLE:
  - On tx_start, latch tx_data into shift[7:0].
  - Compute parity = ~^tx_data (odd parity).
  - Clear ack_ok and timeout; set busy next cycle.
  - Go to INHIBIT.
- INHIBIT:
  - ps2c_pull=1 for exactly INHIBIT_CYCLES cycles.
  - On the final cycle, also assert ps2d_pull=1 (start bit).
  - Go to REQ.
- REQ:
  - ps2c_pull=0, ps2d_pull=1.
  - Bit counter = 0; the timeout counter starts.
  - On fe go to SHIFT with the counter at 0.
- SHIFT:
  - At each fe, present bit n on the line with ps2d_pull = ~bit, then increment n.
  - n=0..7 are data bits, LSB first; n=8 is parity; n=9 is the stop bit, ps2d_pull=0 (release).
  - The fe that presents the stop bit moves the state to ACK.
- ACK:
  - Lines released.
  - On the next fe, sample synced data: ack_ok <= (data==0).
  - Go to WAIT_REL.
- WAIT_REL:
  - Wait until synced clock and synced data are both 1.
  - Then pulse done for one cycle, clear busy, and go to IDLE.

Timeout:
- The counter runs in REQ, SHIFT, ACK and WAIT_REL.
- When it reaches TIMEOUT_CYCLES:
  - release both lines;
  - set timeout=1 and keep ack_ok=0;
  - pulse done;
  - go to IDLE.

Boundary conditions:
- tx_start while busy is ignored; tx_data is not re-sampled.
- tx_start on the same cycle as the done pulse is ignored; it is accepted from the next cycle.
- A device that NACKs (data high at the ACK edge) gives ack_ok=0, timeout=0, and done pulses normally.
- Device clock activity during INHIBIT is ignored.
- fe arriving while a line is already in the target state causes no glitch; the pull enables change only on fe or a state transition.
- Counters:
  - Inhibit counter width is $clog2(INHIBIT_CYCLES+1).
  - Timeout counter width is $clog2(TIMEOUT_CYCLES+1) and saturates.
  - Bit counter is 4 bits.

Decomposition:
- Package ps2_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL};
  - localparams PS2_DATA_BITS=8 and PS2_FRAME_LAST=9;
  - function odd_parity(byte).
- One sub-module, ps2_sync_edge: 2-FF synchronizer plus falling-edge detect, outputs clk_s, dat_s, fe. It is natural to share it with the keyboard receiver.

Test Plan:
1. Reset with the lines idle, then deassert rst_n → all outputs 0 and both pulls 0; a 1-cycle rst_n low pulse during SHIFT → both pulls 0 in the same cycle, state IDLE.
2. tx_start with tx_data=0xED; the device model clocks at 12.5 kHz and ACKs → ps2c_pull high for exactly 5000 cycles; pulled bits match 1,0,1,1,0,1,1,1; parity line value 1; stop released; ack_ok=1, timeout=0, single done pulse.
3. tx_data=0x07 → parity line value 0; ack_ok=1 at done.
4. tx_data=0xFF; the device holds data high at the ACK clock → ack_ok=0, timeout=0, done pulses once, busy then falls.
5. tx_data=0xF4; the device stops clocking after 4 bits → at 750_000 cycles after REQ entry both pulls are 0, timeout=1, done pulses once, ack_ok=0.
6. A second tx_start (0x55) while busy, and a tx_start on the done cycle → both ignored; the frame on the wire is the original byte, and a third tx_start the cycle after done is accepted.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and helpers for the PS/2 host transmitter.
//   tx_state_t     - transmitter FSM states
//   PS2_DATA_BITS  - data bits per frame (sent LSB first)
//   PS2_FRAME_LAST - bit index of the stop bit (0..7 data, 8 parity, 9 stop)
//   odd_parity()   - parity bit that makes the 9-bit data+parity group odd
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_REL
  } tx_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_LAST = 9;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchronizers for the PS/2 clock and data pads plus a
// falling-edge detector on the synchronized clock.
// Ports:
//   clk, rst_n        - system clock, asynchronous active-low reset
//   ps2c_in, ps2d_in  - raw asynchronous pad levels
//   clk_s, dat_s      - synchronized clock / data levels
//   fe                - high for one cycle after the synchronized clock falls
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic clk_s,
  output logic dat_s,
  output logic fe
);

  logic [1:0] c_sync_q;
  logic [1:0] d_sync_q;
  logic       c_prev_q;

  // Reset to the idle bus level (both lines high) so leaving reset never
  // looks like a falling clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      c_prev_q <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_in};
      d_sync_q <= {d_sync_q[0], ps2d_in};
      c_prev_q <= c_sync_q[1];
    end
  end

  assign clk_s = c_sync_q[1];
  assign dat_s = d_sync_q[1];
  assign fe    = c_prev_q & ~c_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Inhibits the bus, requests to send, shifts one byte + odd parity + stop on
// the device's falling clock edges, then samples the device ACK.
// Ports:
//   clk, rst_n             - system clock, asynchronous active-low reset
//   ps2c_in, ps2d_in       - raw PS/2 pad levels (asynchronous)
//   ps2c_pull, ps2d_pull   - 1 = pull the line low, 0 = release
//   tx_data, tx_start      - byte to send and its single-cycle request
//   busy                   - transfer in progress
//   done                   - one-cycle pulse at the end of every transfer
//   ack_ok, timeout        - outcome of the last transfer, held until next start
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int INHIBIT_CYCLES = CLK_HZ / 10_000,      // 100 us
  parameter int TIMEOUT_CYCLES = (CLK_HZ / 1000) * 15  // 15 ms
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_pull,
  output logic       ps2d_pull,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]       BIT_STOP = 4'(PS2_FRAME_LAST);

  logic clk_s, dat_s, fe;

  ps2_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .ps2c_in(ps2c_in),
    .ps2d_in(ps2d_in),
    .clk_s  (clk_s),
    .dat_s  (dat_s),
    .fe     (fe)
  );

  tx_state_t                state_q, state_d;
  logic [PS2_DATA_BITS:0]   shift_q, shift_d;   // {parity, data}
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]         inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
  logic                     ps2c_pull_q, ps2c_pull_d;
  logic                     ps2d_pull_q, ps2d_pull_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ack_ok_q, ack_ok_d;
  logic                     timeout_q, timeout_d;
  logic                     to_active;

  // The timeout window covers everything after the clock line is released.
  assign to_active = (state_q == REQ) || (state_q == SHIFT) ||
                     (state_q == ACK) || (state_q == WAIT_REL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      ps2c_pull_q <= 1'b0;
      ps2d_pull_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_ok_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      ps2c_pull_q <= ps2c_pull_d;
      ps2d_pull_q <= ps2d_pull_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_ok_q    <= ack_ok_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    inh_cnt_d   = inh_cnt_q;
    to_cnt_d    = to_cnt_q;
    ps2c_pull_d = ps2c_pull_q;
    ps2d_pull_d = ps2d_pull_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ack_ok_d    = ack_ok_q;
    timeout_d   = timeout_q;

    if (to_active && (to_cnt_q != TO_MAX)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is dropped on purpose.
        if (tx_start && !done_q) begin
          shift_d     = {odd_parity(tx_data), tx_data};
          ack_ok_d    = 1'b0;
          timeout_d   = 1'b0;
          busy_d      = 1'b1;
          inh_cnt_d   = '0;
          ps2c_pull_d = 1'b1;
          state_d     = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        // Pull data one cycle ahead so the start bit is on the wire during
        // the final inhibit cycle (outputs are registered).
        if (inh_cnt_q == INH_PRE) begin
          ps2d_pull_d = 1'b1;
        end
        if (inh_cnt_q == INH_LAST) begin
          ps2c_pull_d = 1'b0;
          bit_cnt_d   = '0;
          to_cnt_d    = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (fe) begin
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (fe) begin
          if (bit_cnt_q == BIT_STOP) begin
            ps2d_pull_d = 1'b0;
            state_d     = ACK;
          end else begin
            ps2d_pull_d = ~shift_q[bit_cnt_q];
          end
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ACK: begin
        if (fe) begin
          ack_ok_d = ~dat_s;
          state_d  = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever the protocol step decided this cycle.
    if (to_active && (to_cnt_q == TO_LAST)) begin
      ps2c_pull_d = 1'b0;
      ps2d_pull_d = 1'b0;
      timeout_d   = 1'b1;
      ack_ok_d    = 1'b0;
      done_d      = 1'b1;
      busy_d      = 1'b0;
      state_d     = IDLE;
    end
  end

  assign ps2c_pull = ps2c_pull_q;
  assign ps2d_pull = ps2d_pull_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_ok    = ack_ok_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int TO  = 2000;
  localparam int H   = 20;   // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2c_in, ps2d_in, ps2c_pull, ps2d_pull;
  logic       busy, done, ack_ok, timeout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_total <= done_total + 1;
  end

  // Open-drain bus: either side can pull a line low.
  assign ps2c_in = dev_clk & ~ps2c_pull;
  assign ps2d_in = dev_dat & ~ps2d_pull;

  ps2_host_tx #(
    .CLK_HZ        (50_000_000),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_pull(ps2c_pull),
    .ps2d_pull(ps2d_pull),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .done     (done),
    .ack_ok   (ack_ok),
    .timeout  (timeout)
  );

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device model: measures inhibit, clocks nedges falling edges, records the
  // line value seen in each low phase (bits[0]=start ... bits[10]=stop),
  // optionally ACKs, and waits for done.
  task automatic send_frame(input int nedges, input bit ack, input bit inject,
                            input bit wait_done, output int inh_len,
                            output logic start_pull, output logic [10:0] bits,
                            output int req_cyc, output bit got_done,
                            output int done_cyc);
    int guard;
    inh_len = 0; bits = '0; got_done = 1'b0; done_cyc = 0; req_cyc = 0;
    guard = 0;
    while (ps2c_pull !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    while (ps2c_pull === 1'b1 && inh_len < 10 * INH) begin inh_len++; @(negedge clk); end
    req_cyc    = cyc;
    start_pull = ps2d_pull;
    for (int e = 0; e < nedges; e++) begin
      repeat (H) @(negedge clk);
      dev_clk = 1'b0;
      if (inject && e == 2) begin
        tx_data = 8'h55; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
      repeat (H) @(negedge clk);
      bits[e] = ~ps2d_pull;
      dev_clk = 1'b1;
    end
    if (nedges == 11) begin
      repeat (H / 2) @(negedge clk);
      dev_dat = ack ? 1'b0 : 1'b1;
      repeat (H / 2) @(negedge clk);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      dev_dat = 1'b1;
    end
    if (wait_done) begin
      guard = 0;
      while (done !== 1'b1 && guard < 3 * TO) begin @(negedge clk); guard++; end
      got_done = (done === 1'b1);
      done_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    int il, rc, dc; logic sp; logic [10:0] b; bit gd;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({ps2c_pull, ps2d_pull, busy, done, ack_ok, timeout} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {ps2c_pull, ps2d_pull, busy, done, ack_ok, timeout});
    end
    // Start 0xF0 and stop mid-SHIFT: bits 0..2 are 0, so data is pulled.
    start_tx(8'hF0);
    send_frame(4, 1'b1, 1'b0, 1'b0, il, sp, b, rc, gd, dc);
    total++;
    if (ps2d_pull !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_shift: got pull=%b busy=%b expected 1 1", ps2d_pull, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({ps2c_pull, ps2d_pull} !== 2'b00) begin
      bad++;
      $display("FAIL async_reset_release: got %b expected 00", {ps2c_pull, ps2d_pull});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({ps2c_pull, ps2d_pull, busy, done} !== 4'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got %b expected 0000", {ps2c_pull, ps2d_pull, busy, done});
    end
    $display("reset mid-frame: pulls=%b%b busy=%b", ps2c_pull, ps2d_pull, busy);
  endtask

  task automatic test_frame(input string name, input logic [7:0] d, input bit ack,
                            input logic exp_par, input logic [10:0] exp_bits);
    int il, rc, dc, d0; logic sp; logic [10:0] b; bit gd;
    d0 = done_total;
    start_tx(d);
    send_frame(11, ack, 1'b0, 1'b1, il, sp, b, rc, gd, dc);
    $display("frame %s data=%h bits=%b inhibit=%0d ack_ok=%b timeout=%b",
             name, d, b, il, ack_ok, timeout);
    total++;
    if (il !== INH) begin
      bad++; $display("FAIL %s inhibit_len: got %0d expected %0d", name, il, INH);
    end
    total++;
    if (sp !== 1'b1) begin
      bad++; $display("FAIL %s start_bit_pull: got %b expected 1", name, sp);
    end
    total++;
    if (b !== exp_bits) begin
      bad++; $display("FAIL %s frame_bits: got %b expected %b", name, b, exp_bits);
    end
    total++;
    if (b[9] !== exp_par) begin
      bad++; $display("FAIL %s parity: got %b expected %b", name, b[9], exp_par);
    end
    total++;
    if (!gd || ack_ok !== ack || timeout !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s result: got done=%0d ack_ok=%b timeout=%b busy=%b expected 1 %b 0 0",
               name, gd, ack_ok, timeout, busy, ack);
    end
    repeat (3) @(negedge clk);
    total++;
    if (done_total - d0 !== 1) begin
      bad++; $display("FAIL %s done_count: got %0d expected 1", name, done_total - d0);
    end
  endtask

  task automatic test_timeout();
    int il, rc, dc, d0; logic sp; logic [10:0] b; bit gd;
    d0 = done_total;
    start_tx(8'hF4);
    send_frame(5, 1'b1, 1'b0, 1'b1, il, sp, b, rc, gd, dc);
    $display("frame timeout data=f4 bits=%b cycles=%0d timeout=%b", b[4:0], dc - rc, timeout);
    total++;
    if (b[4:0] !== 5'b01000) begin
      bad++; $display("FAIL timeout_partial_bits: got %b expected 01000", b[4:0]);
    end
    total++;
    if (!gd || dc - rc !== TO) begin
      bad++; $display("FAIL timeout_latency: got done=%0d cycles=%0d expected %0d", gd, dc - rc, TO);
    end
    total++;
    if ({ps2c_pull, ps2d_pull, timeout, ack_ok, busy} !== 5'b00100) begin
      bad++;
      $display("FAIL timeout_state: got %b expected 00100",
               {ps2c_pull, ps2d_pull, timeout, ack_ok, busy});
    end
    repeat (3) @(negedge clk);
    total++;
    if (done_total - d0 !== 1) begin
      bad++; $display("FAIL timeout_done_count: got %0d expected 1", done_total - d0);
    end
  endtask

  task automatic test_back_to_back();
    int il, rc, dc; logic sp; logic [10:0] b; bit gd;
    start_tx(8'hED);
    send_frame(11, 1'b1, 1'b1, 1'b1, il, sp, b, rc, gd, dc);
    $display("frame b2b_first data=ed bits=%b done=%0d", b, gd);
    total++;
    if (!gd || b !== 11'b11_1110_1101_0) begin
      bad++; $display("FAIL b2b_first_frame: got done=%0d bits=%b expected 1 11111011010", gd, b);
    end
    // Strobe on the done cycle (ignored) and held into the next (accepted).
    tx_data  = 8'hAA;
    tx_start = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b_start_on_done: got busy=%b expected 0", busy);
    end
    tx_data = 8'h07;
    @(negedge clk);
    tx_start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL b2b_start_after_done: got busy=%b expected 1", busy);
    end
    send_frame(11, 1'b1, 1'b0, 1'b1, il, sp, b, rc, gd, dc);
    $display("frame b2b_third data=07 bits=%b ack_ok=%b", b, ack_ok);
    total++;
    if (!gd || b !== 11'b10_0000_0111_0 || ack_ok !== 1'b1 || il !== INH) begin
      bad++;
      $display("FAIL b2b_third_frame: got done=%0d bits=%b ack_ok=%b inh=%0d expected 1 10000001110 1 %0d",
               gd, b, ack_ok, il, INH);
    end
  endtask

  initial begin
    test_reset();
    test_frame("led_ed", 8'hED, 1'b1, 1'b1, 11'b11_1110_1101_0);
    test_frame("par0_07", 8'h07, 1'b1, 1'b0, 11'b10_0000_0111_0);
    test_frame("nack_ff", 8'hFF, 1'b0, 1'b1, 11'b11_1111_1111_0);
    test_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
